// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Purpose  : Direct-mapped, read-only instruction cache with one-word lines.
//            Hits answer in one cycle; misses issue a single-word read on the
//            memory side and relay the returned word after filling the line.
// Revision : 1.0  initial release
// ============================================================================
module icache #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int NUM_LINES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_read_valid,
    input  logic [ADDR_BITS-1:0] fetch_read_address,
    output logic                 fetch_read_ready,
    output logic [DATA_BITS-1:0] fetch_read_data,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    input  logic                 flush,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);

    localparam int INDEX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_WAIT = 2'd1,
        RELAY     = 2'd2
    } state_t;

    state_t                 state_q, state_d;

    // Line storage: valid bits live with the control state, tag and word
    // arrays are written only on a fill.
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [TAG_BITS-1:0]    tag_q  [NUM_LINES];
    logic [DATA_BITS-1:0]   data_q [NUM_LINES];

    logic                   fetch_read_ready_q, fetch_read_ready_d;
    logic [DATA_BITS-1:0]   fetch_read_data_q,  fetch_read_data_d;
    logic                   mem_read_valid_q,   mem_read_valid_d;
    logic [ADDR_BITS-1:0]   mem_read_address_q, mem_read_address_d;
    logic [15:0]            hit_count_q,        hit_count_d;
    logic [15:0]            miss_count_q,       miss_count_d;

    logic [INDEX_BITS-1:0]  w_req_idx;
    logic [TAG_BITS-1:0]    w_req_tag;
    logic                   w_hit;
    logic [INDEX_BITS-1:0]  w_fill_idx;
    logic [TAG_BITS-1:0]    w_fill_tag;
    logic                   w_fill_en;

    assign w_req_idx  = fetch_read_address[INDEX_BITS-1:0];
    assign w_req_tag  = fetch_read_address[ADDR_BITS-1:INDEX_BITS];
    assign w_hit      = valid_q[w_req_idx] && (tag_q[w_req_idx] == w_req_tag);

    // The fill target is the latched miss address, so the line written is
    // exactly the one requested from memory.
    assign w_fill_idx = mem_read_address_q[INDEX_BITS-1:0];
    assign w_fill_tag = mem_read_address_q[ADDR_BITS-1:INDEX_BITS];

    // Next-state, next-output and fill-enable decode for the control FSM.
    always_comb begin
        state_d            = state_q;
        valid_d            = valid_q;
        fetch_read_ready_d = fetch_read_ready_q;
        fetch_read_data_d  = fetch_read_data_q;
        mem_read_valid_d   = mem_read_valid_q;
        mem_read_address_d = mem_read_address_q;
        hit_count_d        = hit_count_q;
        miss_count_d       = miss_count_q;
        w_fill_en          = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    // Flush wins over any pending request this cycle.
                    valid_d = '0;
                end else if (fetch_read_valid) begin
                    if (w_hit) begin
                        fetch_read_data_d  = data_q[w_req_idx];
                        fetch_read_ready_d = 1'b1;
                        if (hit_count_q != 16'hFFFF) begin
                            hit_count_d = hit_count_q + 16'd1;
                        end
                        state_d = RELAY;
                    end else if (!mem_read_ready) begin
                        // A still-high ready belongs to the previous response;
                        // issuing now would let it be mistaken for ours.
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = fetch_read_address;
                        if (miss_count_q != 16'hFFFF) begin
                            miss_count_d = miss_count_q + 16'd1;
                        end
                        state_d = MISS_WAIT;
                    end
                end
            end

            MISS_WAIT: begin
                if (mem_read_ready) begin
                    w_fill_en            = 1'b1;
                    valid_d[w_fill_idx]  = 1'b1;
                    mem_read_valid_d     = 1'b0;
                    fetch_read_data_d    = mem_read_data;
                    fetch_read_ready_d   = 1'b1;
                    state_d              = RELAY;
                end
            end

            RELAY: begin
                if (!fetch_read_valid) begin
                    fetch_read_ready_d = 1'b0;
                    state_d            = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and registered outputs; reset withdraws any miss at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= IDLE;
            valid_q            <= '0;
            fetch_read_ready_q <= 1'b0;
            fetch_read_data_q  <= '0;
            mem_read_valid_q   <= 1'b0;
            mem_read_address_q <= '0;
            hit_count_q        <= '0;
            miss_count_q       <= '0;
        end else begin
            state_q            <= state_d;
            valid_q            <= valid_d;
            fetch_read_ready_q <= fetch_read_ready_d;
            fetch_read_data_q  <= fetch_read_data_d;
            mem_read_valid_q   <= mem_read_valid_d;
            mem_read_address_q <= mem_read_address_d;
            hit_count_q        <= hit_count_d;
            miss_count_q       <= miss_count_d;
        end
    end

    // Tag and word arrays, written on a fill from the memory response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (w_fill_en) begin
            tag_q[w_fill_idx]  <= w_fill_tag;
            data_q[w_fill_idx] <= mem_read_data;
        end
    end

    assign fetch_read_ready = fetch_read_ready_q;
    assign fetch_read_data  = fetch_read_data_q;
    assign mem_read_valid   = mem_read_valid_q;
    assign mem_read_address = mem_read_address_q;
    assign hit_count        = hit_count_q;
    assign miss_count       = miss_count_q;

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache
// Purpose  : Directed self-checking bench for icache. A transaction-level
//            cache model (valid/tag per line, backing memory image, hit and
//            miss totals) supplies the expected values.
// Revision : 1.0  initial release
// ============================================================================
module tb_icache;

    logic        clk;
    logic        reset;
    logic        fetch_read_valid;
    logic [7:0]  fetch_read_address;
    logic        fetch_read_ready;
    logic [15:0] fetch_read_data;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic        flush;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    icache #(
        .ADDR_BITS (8),
        .DATA_BITS (16),
        .NUM_LINES (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .fetch_read_valid   (fetch_read_valid),
        .fetch_read_address (fetch_read_address),
        .fetch_read_ready   (fetch_read_ready),
        .fetch_read_data    (fetch_read_data),
        .mem_read_valid     (mem_read_valid),
        .mem_read_address   (mem_read_address),
        .mem_read_ready     (mem_read_ready),
        .mem_read_data      (mem_read_data),
        .flush              (flush),
        .hit_count          (hit_count),
        .miss_count         (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [15:0] memv   [256];
    bit          mvalid [16];
    logic [3:0]  mtag   [16];
    logic [15:0] m_hit;
    logic [15:0] m_miss;
    logic [15:0] exp_data;
    logic [7:0]  cur_addr;
    logic        prev_mrv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Per-cycle comparison against the model, sampled 2 time units after
    // each rising edge.
    always @(posedge clk) begin
        #2;
        if (!reset) begin
            chk("hit_count", hit_count, m_hit);
            chk("miss_count", miss_count, m_miss);
            if (fetch_read_ready) chk("fetch_data", fetch_read_data, exp_data);
            if (mem_read_valid)   chk("mem_addr", mem_read_address, cur_addr);
            if (mem_read_valid && !prev_mrv) chk("mrv_rise_vs_ready", mem_read_ready, 1'b0);
        end
        prev_mrv = mem_read_valid;
    end

    // One fetch transaction. want_hit is the hand-derived outcome; the model
    // decides the counters and the expected word. stale = cycles the previous
    // response's ready lingers after this request is raised.
    task automatic do_read(input logic [7:0] a, input bit want_hit, input int lat,
                           input int stale, input bit keep_ready, input bit flush_wait);
        bit mhit;
        mhit     = mvalid[a[3:0]] && (mtag[a[3:0]] == a[7:4]);
        cur_addr = a;
        exp_data = memv[a];
        fetch_read_valid   = 1'b1;
        fetch_read_address = a;
        if (mhit)            m_hit  = sat_inc(m_hit);
        else if (stale == 0) m_miss = sat_inc(m_miss);
        for (int k = 0; k < stale; k++) begin
            @(negedge clk);
            chk("stale_no_issue", {31'd0, mem_read_valid}, 32'd0);
        end
        if (stale > 0) begin
            mem_read_ready = 1'b0;
            if (!mhit) m_miss = sat_inc(m_miss);
        end
        @(negedge clk);
        chk("hit_resp", {31'd0, fetch_read_ready}, {31'd0, want_hit});
        if (want_hit) begin
            chk("hit_no_mem", {31'd0, mem_read_valid}, 32'd0);
        end else begin
            chk("miss_issue", {31'd0, mem_read_valid}, 32'd1);
            chk("miss_addr", mem_read_address, a);
            if (flush_wait) flush = 1'b1;
            repeat (lat) @(negedge clk);
            chk("wait_no_resp", {31'd0, fetch_read_ready}, 32'd0);
            mem_read_ready = 1'b1;
            mem_read_data  = memv[a];
            @(negedge clk);
            chk("fill_ready", {31'd0, fetch_read_ready}, 32'd1);
            chk("fill_mrv_low", {31'd0, mem_read_valid}, 32'd0);
            chk("fill_data", fetch_read_data, memv[a]);
            mvalid[a[3:0]] = 1'b1;
            mtag[a[3:0]]   = a[7:4];
            if (!keep_ready) mem_read_ready = 1'b0;
        end
        fetch_read_valid = 1'b0;
        @(negedge clk);
        chk("release", {31'd0, fetch_read_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) memv[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
        memv[8'h23] = 16'hBEEF;
        memv[8'h05] = 16'h1111;
        memv[8'h15] = 16'h2222;
        model_clear();
        for (int i = 0; i < 16; i++) mtag[i] = 4'h0;
        m_hit = 16'd0; m_miss = 16'd0; exp_data = 16'd0; cur_addr = 8'd0;
        prev_mrv = 1'b0;
        reset = 1'b1; fetch_read_valid = 1'b0; fetch_read_address = 8'd0;
        mem_read_ready = 1'b0; mem_read_data = 16'd0; flush = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_frr",  {31'd0, fetch_read_ready}, 32'd0);
        chk("rst_frd",  fetch_read_data, 32'd0);
        chk("rst_mrv",  {31'd0, mem_read_valid}, 32'd0);
        chk("rst_mra",  mem_read_address, 32'd0);
        chk("rst_hit",  hit_count, 32'd0);
        chk("rst_miss", miss_count, 32'd0);

        // Cold miss then hit
        do_read(8'h23, 1'b0, 3, 0, 1'b0, 1'b0);
        chk("cold_mra",  mem_read_address, 32'h23);
        chk("cold_data", fetch_read_data, 32'hBEEF);
        chk("cold_miss", miss_count, 32'd1);
        do_read(8'h23, 1'b1, 0, 0, 1'b0, 1'b0);
        chk("hit_cnt1",  hit_count, 32'd1);

        // Conflict eviction on index 5
        do_read(8'h05, 1'b0, 1, 0, 1'b0, 1'b0);
        do_read(8'h15, 1'b0, 2, 0, 1'b0, 1'b0);
        do_read(8'h05, 1'b0, 1, 0, 1'b0, 1'b0);
        chk("evict_data", fetch_read_data, 32'h1111);
        chk("evict_mra",  mem_read_address, 32'h05);
        chk("evict_miss", miss_count, 32'd4);

        // Flush in IDLE
        do_read(8'h07, 1'b0, 1, 0, 1'b0, 1'b0);
        flush = 1'b1; model_clear();
        @(negedge clk);
        flush = 1'b0;
        do_read(8'h07, 1'b0, 1, 0, 1'b0, 1'b0);
        chk("flush_miss", miss_count, 32'd6);

        // Flush held through MISS_WAIT, honoured once back in IDLE
        do_read(8'h09, 1'b0, 2, 0, 1'b0, 1'b1);
        @(negedge clk);
        flush = 1'b0; model_clear();
        do_read(8'h09, 1'b0, 1, 0, 1'b0, 1'b0);
        chk("flushw_miss", miss_count, 32'd8);
        chk("flushw_hit",  hit_count, 32'd1);

        // Stale controller ready
        do_read(8'h31, 1'b0, 1, 0, 1'b1, 1'b0);
        do_read(8'h42, 1'b0, 2, 2, 1'b0, 1'b0);
        chk("stale_miss", miss_count, 32'd10);
        do_read(8'h31, 1'b1, 0, 0, 1'b0, 1'b0);
        chk("stale_hit", hit_count, 32'd2);

        // Asynchronous reset while waiting on memory
        fetch_read_valid = 1'b1; fetch_read_address = 8'h50; cur_addr = 8'h50;
        m_miss = sat_inc(m_miss);
        @(negedge clk);
        chk("ar_issue", {31'd0, mem_read_valid}, 32'd1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("ar_mrv",  {31'd0, mem_read_valid}, 32'd0);
        chk("ar_frr",  {31'd0, fetch_read_ready}, 32'd0);
        chk("ar_frd",  fetch_read_data, 32'd0);
        chk("ar_mra",  mem_read_address, 32'd0);
        chk("ar_hit",  hit_count, 32'd0);
        chk("ar_miss", miss_count, 32'd0);
        fetch_read_valid = 1'b0;
        model_clear(); m_hit = 16'd0; m_miss = 16'd0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_read(8'h23, 1'b0, 2, 0, 1'b0, 1'b0);
        chk("ar_refill_miss", miss_count, 32'd1);
        chk("ar_refill_data", fetch_read_data, 32'hBEEF);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache. It sits between one core's fetcher and that fetcher's consumer port on the program-memory controller. Hits are answered locally in one cycle. Misses are forwarded to the controller as a single-word read, and the returned word fills the line before it is relayed to the fetcher. The cache uses the same valid/ready relay handshake on both sides, so neither the fetcher nor the controller changes.

## Interface
- ADDR_BITS, 8, program address width
- DATA_BITS, 16, instruction word width
- NUM_LINES, 16, number of one-word lines; power of two, ≥2; INDEX_BITS = log2(NUM_LINES), TAG_BITS = ADDR_BITS − INDEX_BITS

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- fetch_read_valid  in  1  fetcher request; held high until fetch_read_ready seen, then dropped
- fetch_read_address  in  ADDR_BITS  request address, stable while fetch_read_valid high
- fetch_read_ready  out  1  response valid; held until fetcher drops fetch_read_valid
- fetch_read_data  out  DATA_BITS  instruction word, valid while fetch_read_ready high
- mem_read_valid  out  1  miss request to controller consumer port
- mem_read_address  out  ADDR_BITS  miss address
- mem_read_ready  in  1  controller response valid
- mem_read_data  in  DATA_BITS  controller response word
- flush  in  1  level; invalidates all lines when honoured
- hit_count  out  16  saturating hit counter
- miss_count  out  16  saturating miss counter

## Operation
- Storage: per line, a valid bit, a TAG_BITS tag and a DATA_BITS word.
- Address split: index = address[INDEX_BITS-1:0]; tag = address[ADDR_BITS-1:INDEX_BITS].
- Reset values: every valid bit 0, state IDLE, and every output 0 (fetch_read_ready, fetch_read_data, mem_read_valid, mem_read_address, hit_count, miss_count).
- States: IDLE, MISS_WAIT, RELAY.
- IDLE, checked in this priority order:
  - flush=1: clear all valid bits. A pending request is not serviced this cycle. Stay in IDLE.
  - fetch_read_valid=1 and the line is valid with a matching tag (hit): fetch_read_data ← line word, fetch_read_ready ← 1, hit_count += 1, go to RELAY.
  - fetch_read_valid=1 and miss and mem_read_ready=0: mem_read_valid ← 1, mem_read_address ← fetch_read_address, miss_count += 1, go to MISS_WAIT.
  - Miss while mem_read_ready=1 (controller still relaying a previous response): wait in IDLE. No issue and no count.
- MISS_WAIT, on mem_read_ready=1, in one cycle:
  - Write the line: valid ← 1, tag, word ← mem_read_data.
  - mem_read_valid ← 0.
  - fetch_read_data ← mem_read_data, fetch_read_ready ← 1.
  - Go to RELAY.
- MISS_WAIT otherwise: hold.
- RELAY: on fetch_read_valid=0, fetch_read_ready ← 0 and go to IDLE. Otherwise hold.
- flush is ignored outside IDLE. The requester holds flush until the cache returns to IDLE; the line being filled in MISS_WAIT is then cleared by that flush.
- Counters saturate at 16'hFFFF. Only reset clears them; flush does not.
- Reset asserted mid-miss drops mem_read_valid asynchronously. The controller sees the request withdrawn and resolves its side through its own relay handshake.

## Timing
- Hit latency: request sampled at edge t; fetch_read_ready high after edge t. Response is 1 cycle.
- Miss issue: mem_read_valid high after the same edge t the miss is detected.
- Miss return: mem_read_ready sampled high at edge m; fetch_read_ready high and mem_read_valid low after edge m. The cache adds 0 cycles beyond the controller's latency.
- Release: fetch_read_valid sampled low at edge r; fetch_read_ready low after edge r. The next request is accepted at the earliest at edge r+1.
- mem_read_valid never rises while mem_read_ready is high. This guarantees a stale controller ready is never taken as a new response.
- A fill and a read of the same line are never in the same cycle. One outstanding request at a time.

## Test plan
- Cold miss, then hit:
  - read 0x23, controller returns 0xBEEF after 3 cycles → mem_read_address=0x23, fetch_read_data=0xBEEF, miss_count=1.
  - re-read 0x23 → fetch_read_ready one cycle after request, no mem_read_valid, hit_count=1.
- Conflict eviction, NUM_LINES=16:
  - read 0x05 (returns 0x1111), then 0x15 (returns 0x2222), then 0x05 → three misses.
  - final fetch_read_data=0x1111 with mem_read_address=0x05.
- Flush: fill 0x07, assert flush for 1 cycle in IDLE, read 0x07 → miss issued, miss_count incremented.
- Flush during MISS_WAIT: assert and hold flush while waiting on 0x09 → fill relayed normally, then line cleared in IDLE; next read of 0x09 misses.
- Stale ready: hold mem_read_ready high 2 extra cycles after a response, then issue a new miss → mem_read_valid stays 0 until mem_read_ready=0.
- Async reset mid-MISS_WAIT: mem_read_valid and all outputs drop to 0 before the next edge; a subsequent read of a previously filled address misses.
